// File: rtl/fft_frame_sequencer.sv
// Frame sequencer between the mic deserialiser and a 512-point FFT core.
// After reset it sends one config word to the core. Mic samples are then
// buffered in a small first-word-fall-through FIFO and streamed out as AXI-S
// frames of FRAME_LEN beats, with tlast on the final beat of each frame.
module fft_frame_sequencer #(
  parameter int unsigned FRAME_LEN  = 512,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] CFG_WORD   = 16'h0001
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  output logic [15:0]         cfg_tdata_out,
  output logic                cfg_tvalid_out,
  input  logic                cfg_tready_in,
  output logic [31:0]         fft_tdata_out,
  output logic                fft_tvalid_out,
  output logic                fft_tlast_out,
  input  logic                fft_tready_in,
  output logic [15:0]         frame_count_out,
  output logic                overflow_out,
  output logic                busy_out
);

  localparam int unsigned CntW = $clog2(FRAME_LEN);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_LEN - 1);
  localparam logic [OccW-1:0] FullOcc = OccW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StCfg,
    StIdle,
    StRun,
    StDrain
  } state_e;

  state_e          state_q, state_d;
  logic            cfg_valid_q, cfg_valid_d;
  logic [CntW-1:0] in_cnt_q, in_cnt_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            overflow_q, overflow_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic [15:0] sample16;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        cfg_hs;

  // Fit the sample into the 16-bit real field: sign-extend narrow, truncate wide.
  if (SAMPLE_W >= 16) begin : g_trunc
    assign sample16 = sample_in[15:0];
  end else begin : g_sext
    assign sample16 = {{(16 - SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};
  end

  // FIFO handshake decode; a pop frees a slot for a push in the same cycle.
  always_comb begin
    fifo_empty = (occ_q == '0);
    fifo_full  = (occ_q == FullOcc);
    pop        = !fifo_empty && fft_tready_in;
    push_req   = sample_valid_in && (state_q == StRun);
    push       = push_req && (!fifo_full || pop);
    cfg_hs     = cfg_valid_q && cfg_tready_in;
  end

  // Next-state for the sequencing FSM and the input-side frame counter.
  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    case (state_q)
      StCfg: begin
        if (cfg_hs) state_d = StIdle;
      end
      StIdle: begin
        in_cnt_d = '0;
        if (enable_in) state_d = StRun;
      end
      StRun: begin
        if (push) begin
          if (in_cnt_q == LastIdx) begin
            in_cnt_d = '0;
            // enable is only sampled at the frame boundary
            if (!enable_in) state_d = StDrain;
          end else begin
            in_cnt_d = in_cnt_q + CntW'(1);
          end
        end
      end
      StDrain: begin
        if (fifo_empty && (out_cnt_q == '0)) state_d = StIdle;
      end
      default: state_d = StCfg;
    endcase
    // Registered config valid: stays low while in reset, high for the whole of StCfg.
    cfg_valid_d = (state_d == StCfg);
  end

  // Next-state for FIFO pointers, output beat counter and status.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    out_cnt_d   = out_cnt_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q || (push_req && !push);
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (out_cnt_q == LastIdx) begin
        out_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        out_cnt_d = out_cnt_q + CntW'(1);
      end
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StCfg;
      cfg_valid_q <= 1'b0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      cfg_valid_q <= cfg_valid_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

  // Sample storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= sample16;
  end

  // Outputs; data is forced to zero whenever no beat is offered.
  always_comb begin
    cfg_tdata_out   = CFG_WORD;
    cfg_tvalid_out  = cfg_valid_q;
    fft_tvalid_out  = !fifo_empty;
    fft_tdata_out   = fifo_empty ? 32'h0 : {16'h0, mem_q[rd_ptr_q]};
    fft_tlast_out   = !fifo_empty && (out_cnt_q == LastIdx);
    frame_count_out = frame_cnt_q;
    overflow_out    = overflow_q;
    busy_out        = (state_q == StRun) || (state_q == StDrain);
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: stimulus pushes expected beats into a
// scoreboard queue, a negedge monitor pops and compares every output handshake.
module tb_fft_frame_sequencer;

  localparam int FRAME_LEN = 512;

  logic        clk_in;
  logic        rst_in;
  logic        enable_in;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic [15:0] cfg_tdata_out;
  logic        cfg_tvalid_out;
  logic        cfg_tready_in;
  logic [31:0] fft_tdata_out;
  logic        fft_tvalid_out;
  logic        fft_tlast_out;
  logic        fft_tready_in;
  logic [15:0] frame_count_out;
  logic        overflow_out;
  logic        busy_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cfg_hs  = 0;
  int frame_pos = 0;
  logic [32:0] sb [$];

  bit          stall_q = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  fft_frame_sequencer dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .cfg_tdata_out   (cfg_tdata_out),
    .cfg_tvalid_out  (cfg_tvalid_out),
    .cfg_tready_in   (cfg_tready_in),
    .fft_tdata_out   (fft_tdata_out),
    .fft_tvalid_out  (fft_tvalid_out),
    .fft_tlast_out   (fft_tlast_out),
    .fft_tready_in   (fft_tready_in),
    .frame_count_out (frame_count_out),
    .overflow_out    (overflow_out),
    .busy_out        (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // One-cycle strobe; if the sample should be accepted, queue its expected beat.
  task automatic strobe(input logic [15:0] v, input bit acc);
    logic last;
    sample_in       = v;
    sample_valid_in = 1'b1;
    if (acc) begin
      last = (frame_pos == FRAME_LEN - 1);
      sb.push_back({last, 16'h0, v});
      frame_pos = last ? 0 : frame_pos + 1;
    end
    @(posedge clk_in);
    #1;
    sample_valid_in = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk_in);
    #1;
    check(name, sb.size(), 0);
  endtask

  // Monitor: compare each handshaken beat against the scoreboard, and check
  // that a stalled beat is held unchanged into the next cycle.
  always @(negedge clk_in) begin
    logic [32:0] exp;
    if (rst_in) begin
      if (stall_q) begin
        n_tests++;
        if (!(fft_tvalid_out && fft_tdata_out == held_data && fft_tlast_out == held_last)) begin
          n_fail++;
          $display("FAIL hold: v=%0b d=0x%0h l=%0b, required v=1 d=0x%0h l=%0b",
                   fft_tvalid_out, fft_tdata_out, fft_tlast_out, held_data, held_last);
        end
      end
      if (fft_tvalid_out && fft_tready_in) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL beat: unexpected beat d=0x%0h, required none", fft_tdata_out);
        end else begin
          exp = sb.pop_front();
          if (fft_tdata_out !== exp[31:0] || fft_tlast_out !== exp[32]) begin
            n_fail++;
            $display("FAIL beat: got d=0x%0h l=%0b, expected d=0x%0h l=%0b",
                     fft_tdata_out, fft_tlast_out, exp[31:0], exp[32]);
          end
        end
      end
      stall_q   = fft_tvalid_out && !fft_tready_in;
      held_data = fft_tdata_out;
      held_last = fft_tlast_out;
      if (cfg_tvalid_out && cfg_tready_in) cfg_hs++;
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  hi;
    bit  seen;
    logic [15:0] val;

    rst_in = 1'b0; enable_in = 1'b0; sample_in = '0; sample_valid_in = 1'b0;
    cfg_tready_in = 1'b0; fft_tready_in = 1'b0;
    #3;
    check("rst_cfg_tvalid", cfg_tvalid_out, 0);
    check("rst_cfg_tdata", cfg_tdata_out, 32'h0001);
    check("rst_fft_tvalid", fft_tvalid_out, 0);
    check("rst_frame_count", frame_count_out, 0);
    check("rst_busy", busy_out, 0);
    idle(2);
    rst_in = 1'b1;

    // Config handshake with ready held low for five valid cycles.
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk_in);
      if (cfg_tvalid_out) seen = 1'b1;
    end
    check("cfg_valid_seen", seen, 1);
    hi = 1;
    repeat (4) begin
      @(negedge clk_in);
      if (cfg_tvalid_out) hi++;
    end
    @(posedge clk_in); #1;
    cfg_tready_in = 1'b1;
    @(negedge clk_in);
    if (cfg_tvalid_out) hi++;
    @(negedge clk_in);
    check("cfg_valid_drop", cfg_tvalid_out, 0);
    check("cfg_valid_cycles", hi, 6);
    check("cfg_hs_once", cfg_hs, 1);

    // Frame 1: strobe every 4 cycles, ready always high.
    #1;
    enable_in = 1'b1; fft_tready_in = 1'b1;
    idle(2);
    for (int i = 0; i < FRAME_LEN; i++) begin
      strobe(16'(i), 1'b1);
      idle(3);
    end
    drain("f1_drain");
    check("f1_frame_count", frame_count_out, 1);
    check("f1_overflow", overflow_out, 0);
    check("f1_busy", busy_out, 1);

    // Frame 2a: fill FIFO while stalled, then strobe coincident with a pop.
    val = 16'h1000;
    fft_tready_in = 1'b0;
    for (int k = 0; k < 8; k++) begin strobe(val, 1'b1); val++; end
    fft_tready_in = 1'b1;
    strobe(val, 1'b1); val++;
    idle(12);
    check("f2_pushpop_no_ovf", overflow_out, 0);
    // Frame 2b: ten back-to-back strobes while stalled, last two dropped.
    fft_tready_in = 1'b0;
    for (int k = 0; k < 10; k++) begin strobe(val, k < 8); val++; end
    idle(1);
    check("f2_overflow", overflow_out, 1);
    fft_tready_in = 1'b1;
    for (int k = 17; k < FRAME_LEN; k++) begin
      strobe(val, 1'b1); val++;
      idle(1);
    end
    drain("f2_drain");
    check("f2_frame_count", frame_count_out, 2);

    // Frame 3: enable dropped at sample 100; whole frame still accepted.
    val = 16'h4000;
    for (int k = 0; k < FRAME_LEN; k++) begin
      strobe(val, 1'b1); val++;
      if (k == 99) enable_in = 1'b0;
      idle(1);
    end
    drain("f3_drain");
    idle(3);
    check("f3_frame_count", frame_count_out, 3);
    check("f3_idle_busy", busy_out, 0);
    for (int k = 0; k < 5; k++) begin strobe(val, 1'b0); val++; idle(2); end
    check("f3_ignored_tvalid", fft_tvalid_out, 0);
    check("f3_ignored_count", frame_count_out, 3);

    // Frame 4: reset after 300 samples.
    enable_in = 1'b1;
    idle(2);
    val = 16'h8000;
    for (int k = 0; k < 300; k++) begin strobe(val, 1'b1); val++; idle(1); end
    idle(3);
    check("f4_pre_rst_sb", sb.size(), 0);
    rst_in = 1'b0;
    #1;
    check("rst2_fft_tvalid", fft_tvalid_out, 0);
    check("rst2_fft_tdata", fft_tdata_out, 0);
    check("rst2_fft_tlast", fft_tlast_out, 0);
    check("rst2_frame_count", frame_count_out, 0);
    check("rst2_overflow", overflow_out, 0);
    check("rst2_busy", busy_out, 0);
    check("rst2_cfg_tvalid", cfg_tvalid_out, 0);
    sb.delete();
    frame_pos = 0;
    idle(2);
    rst_in = 1'b1;
    for (int t = 0; t < 50 && cfg_hs < 2; t++) @(posedge clk_in);
    #1;
    check("rst2_cfg_hs", cfg_hs, 2);
    idle(3);
    check("rst2_busy_run", busy_out, 1);
    val = 16'hC000;
    for (int k = 0; k < FRAME_LEN; k++) begin strobe(val, 1'b1); val++; idle(1); end
    drain("f5_drain");
    check("f5_frame_count", frame_count_out, 1);
    idle(20);
    check("cfg_hs_total", cfg_hs, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
